// File: rtl/puf_resp_uart_tx.sv
// rtl/puf_resp_uart_tx.sv - captures a PUF response and streams it out as 8N1 UART bytes, MSB byte first.
module puf_resp_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RESP_W       = 256,
  parameter int NUM_BYTES    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] response,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic              dropped
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int YW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [YW-1:0] BYTE_LAST = YW'(NUM_BYTES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]        state;
  logic [BW-1:0]     baud_cnt;
  logic [2:0]        bit_cnt;
  logic [YW-1:0]     byte_cnt;
  logic [RESP_W-1:0] shift;
  logic [7:0]        cur_byte;
  logic              bit_end;

  // The byte on the wire is always the top byte; the buffer shifts left per byte.
  assign cur_byte = shift[RESP_W-1 -: 8];
  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      dropped    <= resp_valid && (state != IDLE);
      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      end
      // tx is registered and loaded one cycle ahead so it changes exactly on bit boundaries.
      case (state)
        IDLE: begin
          if (resp_valid) begin
            shift    <= response;
            state    <= START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= cur_byte[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == 3'd7) begin
              state   <= STOP;
              bit_cnt <= '0;
              tx      <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= cur_byte[bit_cnt + 3'd1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (byte_cnt == BYTE_LAST) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              shift    <= shift << 8;
              state    <= START;
              tx       <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_resp_uart_tx.sv
// tb/tb_puf_resp_uart_tx.sv - randomized scoreboard bench for puf_resp_uart_tx.
module tb_puf_resp_uart_tx;
  localparam int CPB   = 4;
  localparam int RW    = 256;
  localparam int NB    = 32;
  localparam int FRAME = NB * 10 * CPB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          resp_valid = 1'b0;
  logic [RW-1:0] response = '0;
  logic          tx, busy, frame_done, dropped;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int model_end = 0;
  byte unsigned exp_bytes[$];
  int exp_done[$];
  int exp_drop[$];

  puf_resp_uart_tx #(.CLKS_PER_BIT(CPB), .RESP_W(RW), .NUM_BYTES(NB)) dut (
    .clk(clk), .reset(reset), .resp_valid(resp_valid), .response(response),
    .tx(tx), .busy(busy), .frame_done(frame_done), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] rand_resp();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference model: a frame owns the window [t+1, t+FRAME]; bytes go out MSB byte first.
  always @(posedge clk) begin
    if (reset) begin
      exp_bytes.delete();
      exp_done.delete();
      exp_drop.delete();
      model_end = 0;
    end else if (resp_valid) begin
      if (cyc >= model_end) begin
        for (int b = 0; b < NB; b++) exp_bytes.push_back(response[RW-1-8*b -: 8]);
        model_end = cyc + 1 + FRAME;
        exp_done.push_back(model_end);
      end else begin
        exp_drop.push_back(cyc + 1);
      end
    end
    cyc = cyc + 1;
  end

  int         pos = -1;
  logic [9:0] pat;
  logic       exp_busy, exp_fd, exp_dr;
  byte unsigned nb;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      pos = -1;
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_frame_done", frame_done, 0);
      check("reset_dropped", dropped, 0);
    end else begin
      exp_busy = (cyc < model_end);
      check("busy", busy, exp_busy);
      if (pos < 0) begin
        if (exp_busy) begin
          check("byte_available", exp_bytes.size() > 0, 1);
          if (exp_bytes.size() > 0) begin
            nb  = exp_bytes.pop_front();
            pat = {1'b1, nb, 1'b0};
            pos = 0;
          end
        end else begin
          check("tx_idle", tx, 1);
        end
      end
      if (pos >= 0) begin
        check("tx_bit", tx, pat[pos / CPB]);
        pos++;
        if (pos == 10 * CPB) pos = -1;
      end
      exp_fd = (exp_done.size() > 0) && (exp_done[0] == cyc);
      if (exp_fd || frame_done) begin
        check("frame_done", frame_done, exp_fd);
        if (exp_fd) void'(exp_done.pop_front());
      end
      exp_dr = (exp_drop.size() > 0) && (exp_drop[0] == cyc);
      if (exp_dr || dropped) begin
        check("dropped", dropped, exp_dr);
        if (exp_dr) void'(exp_drop.pop_front());
      end
    end
  end

  task automatic send(input logic [RW-1:0] r, input int n);
    response   = r;
    resp_valid = 1'b1;
    repeat (n) @(negedge clk);
    resp_valid = 1'b0;
    response   = rand_resp();
  endtask

  task automatic wait_idle();
    int lim = 0;
    while (cyc < model_end + 2 && lim < 3 * FRAME) begin
      @(negedge clk);
      lim++;
    end
    check("wait_bound", lim < 3 * FRAME, 1);
  endtask

  initial begin
    logic [RW-1:0] r;
    int t;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (1000) @(negedge clk);

    for (int i = 0; i < NB; i++) r[RW-1-8*i -: 8] = 8'(i + 1);
    send(r, 1);
    wait_idle();

    for (int i = 0; i < NB; i++) r[8*i +: 8] = 8'hA5;
    send(r, 1);
    wait_idle();

    send(rand_resp(), 1);
    repeat (49) @(negedge clk);
    send(rand_resp(), 1);
    wait_idle();

    send(rand_resp(), 1);
    while (cyc != model_end) @(negedge clk);
    send(rand_resp(), 1);
    wait_idle();

    send(rand_resp(), 3);
    wait_idle();

    t = cyc;
    send(rand_resp(), 1);
    while (cyc < t + 1 + 10 * 10 * CPB + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    send(rand_resp(), 1);
    wait_idle();

    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send(rand_resp(), $urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, FRAME - 10)) @(negedge clk);
        send(rand_resp(), 1);
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("bytes_left", exp_bytes.size(), 0);
    check("frame_done_left", exp_done.size(), 0);
    check("dropped_left", exp_drop.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
